// File: rtl/mem_arbiter_n_if.sv
// mem_arbiter_n_if: per-port request/response bus and downstream adaptor bus of the N-port line arbiter
interface mem_arbiter_n_if #(
  parameter int N_PORTS = 2,
  parameter int s_offset = 5
);
  localparam int LINE = (2**s_offset)*8;
  localparam int GW = N_PORTS > 1 ? $clog2(N_PORTS) : 1;
  logic [N_PORTS-1:0] read_i;
  logic [N_PORTS-1:0] write_i;
  logic [N_PORTS*32-1:0] address_i;
  logic [N_PORTS*LINE-1:0] line_i;
  logic [N_PORTS-1:0] resp_o;
  logic [LINE-1:0] line_o;
  logic [GW-1:0] grant_o;
  logic mem_read_o;
  logic mem_write_o;
  logic [31:0] mem_address_o;
  logic [LINE-1:0] mem_line_o;
  logic [LINE-1:0] mem_line_i;
  logic mem_resp_i;
  modport master (
    output read_i, write_i, address_i, line_i, mem_line_i, mem_resp_i,
    input resp_o, line_o, grant_o, mem_read_o, mem_write_o, mem_address_o, mem_line_o
  );
  modport slave (
    input read_i, write_i, address_i, line_i, mem_line_i, mem_resp_i,
    output resp_o, line_o, grant_o, mem_read_o, mem_write_o, mem_address_o, mem_line_o
  );
endinterface

// File: rtl/mem_arbiter_n.sv
// mem_arbiter_n: N-port line arbiter, one outstanding transaction; MEM_ARB_PERF_CNT_EN adds per-port grant counters
module mem_arbiter_n #(
  parameter int N_PORTS = 2,
  parameter int s_offset = 5,
  parameter int RR_EN = 1
) (
  input logic clk,
  input logic reset_n,
  mem_arbiter_n_if.slave bus
`ifdef MEM_ARB_PERF_CNT_EN
  ,
  output logic [N_PORTS*32-1:0] perf_grant_cnt_o
`endif
);
  localparam int LINE = (2**s_offset)*8;
  localparam int GW = N_PORTS > 1 ? $clog2(N_PORTS) : 1;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_nx;
  logic [N_PORTS-1:0] req;
  logic any;
  logic found;
  logic [GW-1:0] win;
  logic [GW-1:0] ptr;
  int k;
  assign req = bus.read_i | bus.write_i;
  assign any = |req;
  assign bus.line_o = bus.mem_line_i;
  // winner search: scan from the round-robin pointer (or from 0 in fixed priority)
  always_comb begin
    win = '0;
    found = 1'b0;
    k = 0;
    for (int i = 0; i < N_PORTS; i++) begin
      k = RR_EN != 0 ? (int'(ptr) + i) % N_PORTS : i;
      if (!found && req[k]) begin
        win = GW'(k);
        found = 1'b1;
      end
    end
  end
  // next state and the completion pulse to the owner
  always_comb begin
    state_nx = (state == IDLE && any) ? BUSY :
               (state == BUSY && bus.mem_resp_i) ? DONE :
               (state == DONE) ? IDLE : state;
    bus.resp_o = (state == BUSY && bus.mem_resp_i) ? N_PORTS'(1) << bus.grant_o : '0;
  end
  // state register
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nx;
  // capture the winner's request on grant, drop the strobe on completion
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      bus.mem_read_o <= 1'b0;
      bus.mem_write_o <= 1'b0;
      bus.mem_address_o <= '0;
      bus.mem_line_o <= '0;
      bus.grant_o <= '0;
      ptr <= '0;
    end else if (state == IDLE && any) begin
      bus.mem_read_o <= bus.read_i[win] & ~bus.write_i[win];
      bus.mem_write_o <= bus.write_i[win];
      bus.mem_address_o <= bus.address_i[int'(win)*32 +: 32];
      bus.mem_line_o <= bus.line_i[int'(win)*LINE +: LINE];
      bus.grant_o <= win;
      ptr <= GW'((int'(win) + 1) % N_PORTS);
    end else if (state == BUSY && bus.mem_resp_i) begin
      bus.mem_read_o <= 1'b0;
      bus.mem_write_o <= 1'b0;
    end
`ifdef MEM_ARB_PERF_CNT_EN
  // saturating grant count per port
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) perf_grant_cnt_o <= '0;
    else if (state == IDLE && any && perf_grant_cnt_o[int'(win)*32 +: 32] != 32'hFFFF_FFFF)
      perf_grant_cnt_o[int'(win)*32 +: 32] <= perf_grant_cnt_o[int'(win)*32 +: 32] + 32'd1;
`endif
endmodule

// File: tb/tb_mem_arbiter_n.sv
// tb_mem_arbiter_n: directed checks of the N-port line arbiter (2-port default, 4-port round-robin, 4-port fixed)
module tb_mem_arbiter_n;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int total = 0;
  int passed = 0;
  int failed = 0;
  logic [255:0] wline;
  int g;
  always #5 clk = ~clk;
  mem_arbiter_n_if #(.N_PORTS(2)) a_if ();
  mem_arbiter_n_if #(.N_PORTS(4)) b_if ();
  mem_arbiter_n_if #(.N_PORTS(4)) c_if ();
`ifdef MEM_ARB_PERF_CNT_EN
  logic [63:0] a_cnt;
  logic [127:0] b_cnt;
  logic [127:0] c_cnt;
`endif
  mem_arbiter_n #(.N_PORTS(2)) u_a (
    .clk(clk), .reset_n(reset_n), .bus(a_if.slave)
`ifdef MEM_ARB_PERF_CNT_EN
    , .perf_grant_cnt_o(a_cnt)
`endif
  );
  mem_arbiter_n #(.N_PORTS(4), .RR_EN(1)) u_b (
    .clk(clk), .reset_n(reset_n), .bus(b_if.slave)
`ifdef MEM_ARB_PERF_CNT_EN
    , .perf_grant_cnt_o(b_cnt)
`endif
  );
  mem_arbiter_n #(.N_PORTS(4), .RR_EN(0)) u_c (
    .clk(clk), .reset_n(reset_n), .bus(c_if.slave)
`ifdef MEM_ARB_PERF_CNT_EN
    , .perf_grant_cnt_o(c_cnt)
`endif
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [255:0] o, input logic [255:0] e);
    total++;
    assert (o === e) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask
  initial begin
    a_if.read_i = '0; a_if.write_i = '0; a_if.address_i = '0; a_if.line_i = '0;
    a_if.mem_line_i = '0; a_if.mem_resp_i = 1'b0;
    b_if.read_i = '0; b_if.write_i = '0; b_if.address_i = '0; b_if.line_i = '0;
    b_if.mem_line_i = '0; b_if.mem_resp_i = 1'b0;
    c_if.read_i = '0; c_if.write_i = '0; c_if.address_i = '0; c_if.line_i = '0;
    c_if.mem_line_i = '0; c_if.mem_resp_i = 1'b0;
    repeat (2) tick;
    chk("rst_rd", a_if.mem_read_o, 0);
    chk("rst_wr", a_if.mem_write_o, 0);
    chk("rst_resp", a_if.resp_o, 0);
    chk("rst_addr", a_if.mem_address_o, 0);
    chk("rst_line", a_if.mem_line_o, 0);
    chk("rst_grant", a_if.grant_o, 0);
    @(negedge clk) reset_n = 1'b1;
    tick;
    a_if.address_i = {32'h0000_1240, 32'h0};
    a_if.read_i = 2'b10;
    tick;
    chk("rd_en", a_if.mem_read_o, 1);
    chk("rd_wr", a_if.mem_write_o, 0);
    chk("rd_addr", a_if.mem_address_o, 32'h0000_1240);
    chk("rd_grant", a_if.grant_o, 1);
    repeat (3) tick;
    chk("rd_hold", a_if.mem_read_o, 1);
    chk("rd_nresp", a_if.resp_o, 0);
    a_if.mem_line_i = {32{8'hA5}};
    a_if.mem_resp_i = 1'b1;
    #1;
    chk("rd_resp", a_if.resp_o, 2'b10);
    chk("rd_line", a_if.line_o, {32{8'hA5}});
    tick;
    a_if.mem_resp_i = 1'b0;
    a_if.read_i = '0;
    chk("rd_drop", a_if.mem_read_o, 0);
    chk("rd_done_resp", a_if.resp_o, 0);
    tick;
    wline = {4{64'h0123_4567_89AB_CDEF}};
    a_if.address_i = {32'h0, 32'h80};
    a_if.line_i = {256'h0, wline};
    a_if.read_i = 2'b01;
    a_if.write_i = 2'b01;
    tick;
    chk("wr_en", a_if.mem_write_o, 1);
    chk("wr_rd", a_if.mem_read_o, 0);
    chk("wr_line", a_if.mem_line_o, wline);
    chk("wr_addr", a_if.mem_address_o, 32'h80);
    chk("wr_grant", a_if.grant_o, 0);
    a_if.line_i = '1;
    repeat (2) tick;
    chk("wr_hold", a_if.mem_line_o, wline);
    chk("wr_hold_en", a_if.mem_write_o, 1);
    a_if.mem_resp_i = 1'b1;
    #1;
    chk("wr_resp", a_if.resp_o, 2'b01);
    tick;
    chk("wr_done_resp", a_if.resp_o, 0);
    chk("wr_drop", a_if.mem_write_o, 0);
    a_if.read_i = '0;
    a_if.write_i = '0;
    tick;
    a_if.mem_resp_i = 1'b0;
    a_if.address_i = {32'h0, 32'h300};
    a_if.read_i = 2'b01;
    tick;
    chk("dr_en", a_if.mem_read_o, 1);
    a_if.read_i = '0;
    tick;
    a_if.mem_resp_i = 1'b1;
    #1;
    chk("dr_resp", a_if.resp_o, 2'b01);
    tick;
    a_if.mem_resp_i = 1'b0;
    tick;
    a_if.mem_resp_i = 1'b1;
    #1;
    chk("st_resp", a_if.resp_o, 0);
    tick;
    chk("st_rd", a_if.mem_read_o, 0);
    chk("st_wr", a_if.mem_write_o, 0);
    a_if.mem_resp_i = 1'b0;
    a_if.address_i = {32'h0000_2000, 32'h0};
    a_if.read_i = 2'b10;
    tick;
    chk("st_next", a_if.mem_read_o, 1);
    chk("st_grant", a_if.grant_o, 1);
    tick;
    #2;
    reset_n = 1'b0;
    a_if.mem_resp_i = 1'b1;
    #1;
    chk("mr_rd", a_if.mem_read_o, 0);
    chk("mr_addr", a_if.mem_address_o, 0);
    chk("mr_grant", a_if.grant_o, 0);
    chk("mr_resp", a_if.resp_o, 0);
    a_if.mem_resp_i = 1'b0;
    a_if.read_i = '0;
    @(negedge clk) reset_n = 1'b1;
    tick;
    a_if.address_i = {32'h0, 32'h44};
    a_if.read_i = 2'b01;
    tick;
    chk("mr_idle", a_if.mem_read_o, 1);
    chk("mr_idle_addr", a_if.mem_address_o, 32'h44);
    a_if.mem_resp_i = 1'b1;
    tick;
    a_if.read_i = '0;
    a_if.mem_resp_i = 1'b0;
    tick;
    b_if.address_i = {32'h3000, 32'h2000, 32'h1000, 32'h0};
    b_if.read_i = 4'hF;
    for (int j = 0; j < 5; j++) begin
      g = j % 4;
      tick;
      chk("rr_grant", b_if.grant_o, g);
      chk("rr_addr", b_if.mem_address_o, 32'h1000 * g);
      b_if.mem_resp_i = 1'b1;
      #1;
      chk("rr_resp", b_if.resp_o, 4'b0001 << g);
      tick;
      b_if.mem_resp_i = 1'b0;
      tick;
    end
    b_if.read_i = '0;
    c_if.address_i = {32'h3000, 32'h2000, 32'h1000, 32'h0};
    c_if.read_i = 4'b0101;
    for (int j = 0; j < 4; j++) begin
      g = j < 3 ? 0 : 2;
      tick;
      chk("fp_grant", c_if.grant_o, g);
      chk("fp_rd", c_if.mem_read_o, 1);
      if (j == 2) c_if.read_i = 4'b0100;
      c_if.mem_resp_i = 1'b1;
      #1;
      chk("fp_resp", c_if.resp_o, 4'b0001 << g);
      tick;
      c_if.mem_resp_i = 1'b0;
      tick;
    end
    c_if.read_i = '0;
    tick;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
